// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the MEM-stage load/store unit.
//               FSM state encoding, funct3 access-size codes and the
//               byte-enable generator used by the store lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size is carried by funct3[1:0]; reserved codes fall into the word case.
    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               Store side: byte enables and lane replication of store data.
//               Load side : byte/half extraction with sign or zero extension.
// Ports       : st_funct3/st_lo/st_data -> st_be/st_lanes   (store path)
//               ld_funct3/ld_lo/ld_word -> ld_data           (load path)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_lo,
    input  logic [DW-1:0]   st_data,
    output logic [DW/8-1:0] st_be,
    output logic [DW-1:0]   st_lanes,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_lo,
    input  logic [DW-1:0]   ld_word,
    output logic [DW-1:0]   ld_data
);

    logic [DW-1:0] w_byte_sh;
    logic [DW-1:0] w_half_sh;

    // Shift the addressed byte/half down to bit 0 before extension.
    assign w_byte_sh = ld_word >> {ld_lo, 3'b000};
    assign w_half_sh = ld_word >> {ld_lo[1], 4'b0000};

    always_comb begin
        st_be = lsu_be(st_funct3, st_lo);
        case (st_funct3[1:0])
            2'b00:   st_lanes = {4{st_data[7:0]}};
            2'b01:   st_lanes = {2{st_data[15:0]}};
            default: st_lanes = st_data;
        endcase
    end

    always_comb begin
        case (ld_funct3)
            F3_B:    ld_data = {{(DW-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
            F3_BU:   ld_data = {{(DW-8){1'b0}}, w_byte_sh[7:0]};
            F3_H:    ld_data = {{(DW-16){w_half_sh[15]}}, w_half_sh[15:0]};
            F3_HU:   ld_data = {{(DW-16){1'b0}}, w_half_sh[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_if
// Description : MEM-stage load/store unit. Turns load/store controls into a
//               valid/ready bus transaction, aligns store data, formats load
//               data into the registered rdata and stalls the pipeline until
//               the access completes (stall releases in the DONE cycle).
// Ports       : clk, rst_n (async, active-low)
//               mem_read, mem_write, funct3, addr, wdata   - MEM-stage controls
//               rdata, stall, misalign                     - to pipeline
//               bus_req_valid/ready, bus_we, bus_addr, bus_be, bus_wdata
//               bus_rsp_valid, bus_rsp_data                - data bus
// Options     : LSU_MISALIGN_TRAP_EN - misaligned half/word accesses skip the
//               bus and flag misalign for one cycle; otherwise the low
//               address bits are truncated and misalign stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata,
    output logic            stall,
    output logic            misalign,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_be,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_rsp_valid,
    input  logic [DW-1:0]   bus_rsp_data
);

    lsu_state_e      r_state;
    lsu_state_e      w_state_nxt;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lo;
    logic            r_misalign;
    logic            w_op;
    logic            w_trap;
    logic [DW/8-1:0] w_st_be;
    logic [DW-1:0]   w_st_lanes;
    logic [DW-1:0]   w_ld_data;

    assign w_op = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need addr[0]=0; words and reserved sizes need addr[1:0]=0.
    always_comb begin
        w_trap = 1'b0;
        if (funct3[1:0] == 2'b01)
            w_trap = addr[0];
        else if (funct3[1])
            w_trap = (addr[1:0] != 2'b00);
    end
`else
    assign w_trap = 1'b0;
`endif

    lsu_align #(
        .DW(DW)
    ) u_align (
        .st_funct3 (funct3),
        .st_lo     (addr[1:0]),
        .st_data   (wdata),
        .st_be     (w_st_be),
        .st_lanes  (w_st_lanes),
        .ld_funct3 (r_funct3),
        .ld_lo     (r_lo),
        .ld_word   (bus_rsp_data),
        .ld_data   (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus_req_valid = 1'b0;
        stall         = 1'b0;
        case (r_state)
            IDLE: if (w_op) w_state_nxt = w_trap ? DONE : REQ;
            REQ: begin
                bus_req_valid = 1'b1;
                // bus_we was registered from the op, so it tells store from load.
                if (bus_req_ready) w_state_nxt = bus_we ? DONE : RESP;
            end
            RESP: if (bus_rsp_valid) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        stall = w_op & (r_state != DONE);
    end

    // Request fields are captured once in IDLE and held until the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            r_funct3   <= 3'b000;
            r_lo       <= 2'b00;
            r_misalign <= 1'b0;
            rdata      <= '0;
        end else begin
            r_misalign <= 1'b0;
            if (r_state == IDLE && w_op) begin
                if (w_trap) begin
                    r_misalign <= 1'b1;
                end else begin
                    bus_we    <= mem_write;
                    bus_addr  <= {addr[AW-1:2], 2'b00};
                    bus_be    <= w_st_be;
                    bus_wdata <= w_st_lanes;
                    r_funct3  <= funct3;
                    r_lo      <= addr[1:0];
                end
            end
            if (r_state == RESP && bus_rsp_valid)
                rdata <= w_ld_data;
        end
    end

    // Only set on the trap path, so it is high exactly in that DONE cycle.
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_if
// Description : Directed self-checking bench for lsu_mem_if.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_data = '0;

    int checks = 0;
    int errors = 0;

    lsu_mem_if #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .stall         (stall),
        .misalign      (misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_data  (bus_rsp_data)
    );

    always #5 clk = ~clk;

    // Drive point: just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus_req_valid); end
        checks++; if ({bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin errors++; $display("FAIL rst_bus got %b/%h/%b/%h want zeros", bus_we, bus_addr, bus_be, bus_wdata); end
        checks++; if (rdata !== 32'h0 || misalign !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_out got rdata=%h mis=%b stall=%b want 0/0/0", rdata, misalign, stall); end
        step();
        rst_n = 1'b1;
        step();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; bus_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b1) begin errors++; $display("FAIL rst_midreq_pre got %b want 1", bus_req_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_midreq_drop got %b want 0", bus_req_valid); end
        checks++; if (bus_addr !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_midreq_regs got addr=%h rdata=%h want 0/0", bus_addr, rdata); end
        step();
        mem_read = 1'b0; rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEADBEEF;
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (rdata !== 32'h0 || bus_req_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_late_rsp got rdata=%h valid=%b stall=%b want 0/0/0", rdata, bus_req_valid, stall); end
    endtask

    task automatic test_sb();
        step();
        mem_write = 1'b1; funct3 = 3'b000; addr = 32'h1003; wdata = 32'h000000A5; bus_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL sb_idle got stall=%b valid=%b want 1/0", stall, bus_req_valid); end
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b1 || bus_we !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_req got valid=%b we=%b stall=%b want 1/1/1", bus_req_valid, bus_we, stall); end
        checks++; if (bus_addr !== 32'h1000 || bus_be !== 4'b1000 || bus_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_fields got %h/%b/%h want 00001000/1000/a5a5a5a5", bus_addr, bus_be, bus_wdata); end
        @(negedge clk);
        checks++; if (stall !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL sb_done got stall=%b valid=%b want 0/0", stall, bus_req_valid); end
        step();
        mem_write = 1'b0; bus_req_ready = 1'b0;
    endtask

    task automatic test_sh();
        step();
        mem_write = 1'b1; funct3 = 3'b001; addr = 32'h1001; wdata = 32'h1234BEEF; bus_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_be !== 4'b0011 || bus_wdata !== 32'hBEEFBEEF || bus_addr !== 32'h1000) begin errors++; $display("FAIL sh_fields got %b/%h/%h want 0011/beefbeef/00001000", bus_be, bus_wdata, bus_addr); end
        @(negedge clk);
        step();
        mem_write = 1'b0; bus_req_ready = 1'b0;
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        step();
        mem_read = 1'b1; funct3 = f3; addr = 32'h2002; bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h2000) begin errors++; $display("FAIL lb_req f3=%b got valid=%b we=%b addr=%h want 1/0/00002000", f3, bus_req_valid, bus_we, bus_addr); end
        step();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h12F45678;
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rdata !== exp) begin errors++; $display("FAIL lb_data f3=%b got stall=%b rdata=%h want 0/%h", f3, stall, rdata, exp); end
        step();
        mem_read = 1'b0;
    endtask

    task automatic test_lh_backpressure();
        step();
        mem_read = 1'b1; funct3 = 3'b001; addr = 32'h2002; bus_req_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_req_valid !== 1'b1 || bus_addr !== 32'h2000 || bus_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL lh_hold%0d got valid=%b addr=%h we=%b stall=%b want 1/00002000/0/1", i, bus_req_valid, bus_addr, bus_we, stall); end
            @(posedge clk);
            #1;
        end
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b0 || stall !== 1'b1 || rdata !== 32'h000000F4) begin errors++; $display("FAIL lh_wait got valid=%b stall=%b rdata=%h want 0/1/000000f4", bus_req_valid, stall, rdata); end
        step();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h8001ABCD;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lh_resp_stall got %b want 1", stall); end
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_done got stall=%b rdata=%h want 0/ffff8001", stall, rdata); end
        step();
        mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        step();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h3000; bus_req_ready = 1'b1;
        @(posedge clk);
        step();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hCAFEF00D;
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw got stall=%b rdata=%h want 0/cafef00d", stall, rdata); end
        step();
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'h3004; wdata = 32'h11223344;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got stall=%b valid=%b want 1/0", stall, bus_req_valid); end
        step();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h55555555;
        @(negedge clk);
        checks++; if (bus_we !== 1'b1 || bus_be !== 4'b1111 || bus_wdata !== 32'h11223344 || bus_addr !== 32'h3004) begin errors++; $display("FAIL b2b_sw got we=%b be=%b wd=%h addr=%h want 1/1111/11223344/00003004", bus_we, bus_be, bus_wdata, bus_addr); end
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rdata !== 32'hCAFEF00D || misalign !== 1'b0) begin errors++; $display("FAIL b2b_keep got stall=%b rdata=%h mis=%b want 0/cafef00d/0", stall, rdata, misalign); end
        step();
        mem_write = 1'b0; bus_req_ready = 1'b0;
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        step();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h3001; bus_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b1 || misalign !== 1'b0) begin errors++; $display("FAIL mis_idle got stall=%b mis=%b want 1/0", stall, misalign); end
        @(negedge clk);
        checks++; if (misalign !== 1'b1 || bus_req_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_done got mis=%b valid=%b stall=%b rdata=%h want 1/0/0/cafef00d", misalign, bus_req_valid, stall, rdata); end
        step();
        mem_read = 1'b0; bus_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (misalign !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL mis_after got mis=%b valid=%b want 0/0", misalign, bus_req_valid); end
    endtask
`else
    task automatic test_misalign();
        step();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h3001; bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b1 || bus_addr !== 32'h3000 || misalign !== 1'b0) begin errors++; $display("FAIL trunc_req got valid=%b addr=%h mis=%b want 1/00003000/0", bus_req_valid, bus_addr, misalign); end
        step();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0BADF00D;
        step();
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (rdata !== 32'h0BADF00D || misalign !== 1'b0) begin errors++; $display("FAIL trunc_data got rdata=%h mis=%b want 0badf00d/0", rdata, misalign); end
        step();
        mem_read = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_load_byte(3'b000, 32'hFFFFFFF4);
        test_load_byte(3'b100, 32'h000000F4);
        test_lh_backpressure();
        test_back_to_back();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
